// File: rtl/tile_reset_pkg.sv
// Shared types and register offsets for the per-tile reset controller.
package tile_reset_pkg;

  // Per-tile reset sequencing states
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HOLD   = 2'd1,
    PARKED = 2'd2
  } tile_state_e;

  // Byte offsets of the register map
  localparam int unsigned CTRL_BASE  = 32'h000;
  localparam int unsigned STATUS_OFF = 32'h100;
  localparam int unsigned PULSE_OFF  = 32'h108;
  localparam int unsigned BUSY_OFF   = 32'h110;

endpackage

// File: rtl/tile_reset_fsm.sv
// One tile's reset sequencer: guarantees HOLD_CYCLES of reset, then parks or runs.
module tile_reset_fsm
  import tile_reset_pkg::*;
#(
  parameter int HOLD_CYCLES = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic ctrl,
  input  logic pulse,
  output logic tile_reset,
  output logic busy
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

  tile_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State, hold counter and registered reset output; reset restarts a full hold
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= HOLD;
      cnt_q      <= '0;
      tile_reset <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tile_reset <= (state_d != RUN);
    end
  end

  // Next state: pulses restart the hold, ctrl only picks where the hold exits to
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (pulse || ctrl) begin
          state_d = HOLD;
          cnt_d   = '0;
        end
      end
      HOLD: begin
        if (pulse) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ctrl ? PARKED : RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PARKED: begin
        if (!ctrl) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = HOLD;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy = (state_q == HOLD);

endmodule

// File: rtl/tile_reset_seq_ctrl.sv
// Register-mapped per-tile reset controller with a single-beat request/response port.
module tile_reset_seq_ctrl
  import tile_reset_pkg::*;
#(
  parameter int                 N_TILES     = 6,
  parameter int                 HOLD_CYCLES = 16,
  parameter logic [N_TILES-1:0] RESET_INIT  = {N_TILES{1'b1}},
  parameter int                 ADDR_W      = 12,
  parameter int                 SRC_W       = 12
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic [63:0]        req_wdata,
  input  logic [7:0]         req_wmask,
  input  logic [SRC_W-1:0]   req_source,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [63:0]        rsp_data,
  output logic [SRC_W-1:0]   rsp_source,
  output logic               rsp_denied,
  output logic [N_TILES-1:0] tile_reset
);

  localparam int WORD_W       = ADDR_W - 3;
  localparam int N_CTRL_WORDS = (N_TILES + 1) / 2;
  localparam logic [WORD_W-1:0] CTRL_WORD0  = WORD_W'(CTRL_BASE >> 3);
  localparam logic [WORD_W-1:0] STATUS_WORD = WORD_W'(STATUS_OFF >> 3);
  localparam logic [WORD_W-1:0] PULSE_WORD  = WORD_W'(PULSE_OFF >> 3);
  localparam logic [WORD_W-1:0] BUSY_WORD   = WORD_W'(BUSY_OFF >> 3);

  logic [WORD_W-1:0]  word_idx;
  logic [WORD_W-1:0]  ctrl_word;
  logic               accept;
  logic               hit_ctrl, hit_status, hit_pulse, hit_busy, hit_any;
  logic [N_TILES-1:0] ctrl_q, ctrl_d, pulse, tile_busy;
  logic [63:0]        rd_data;
  logic               unused_bits;

  assign word_idx   = req_addr[ADDR_W-1:3];
  assign ctrl_word  = word_idx - CTRL_WORD0;
  assign hit_ctrl   = (word_idx >= CTRL_WORD0) && (ctrl_word < WORD_W'(N_CTRL_WORDS));
  assign hit_status = (word_idx == STATUS_WORD);
  assign hit_pulse  = (word_idx == PULSE_WORD);
  assign hit_busy   = (word_idx == BUSY_WORD);
  assign hit_any    = hit_ctrl | hit_status | hit_pulse | hit_busy;
  assign req_ready  = !rsp_valid || rsp_ready;
  assign accept     = req_valid && req_ready;
  assign unused_bits = ^{req_addr[2:0], req_wdata, req_wmask};

  // Next CTRL value; fed straight to the tiles so a write acts on its accept edge
  always_comb begin
    ctrl_d = ctrl_q;
    if (accept && req_write && hit_ctrl) begin
      for (int i = 0; i < N_TILES; i++) begin
        if (ctrl_word == WORD_W'(i / 2) && req_wmask[(i % 2) * 4]) begin
          ctrl_d[i] = req_wdata[(i % 2) * 32];
        end
      end
    end
  end

  // Self-clearing pulse triggers, one per tile, gated by the byte mask
  always_comb begin
    pulse = '0;
    for (int i = 0; i < N_TILES; i++) begin
      pulse[i] = accept && req_write && hit_pulse && req_wdata[i] && req_wmask[i / 8];
    end
  end

  // Read mux over the pre-update register state
  always_comb begin
    rd_data = '0;
    if (hit_ctrl) begin
      for (int i = 0; i < N_TILES; i++) begin
        if (ctrl_word == WORD_W'(i / 2)) begin
          rd_data[(i % 2) * 32] = ctrl_q[i];
        end
      end
    end else if (hit_status) begin
      rd_data[N_TILES-1:0] = tile_reset;
    end else if (hit_busy) begin
      rd_data[N_TILES-1:0] = tile_busy;
    end
  end

  // Sticky CTRL bits
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q <= RESET_INIT;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

  // One-entry response buffer, held until the consumer takes it
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_source <= '0;
      rsp_denied <= 1'b0;
    end else if (accept) begin
      rsp_valid  <= 1'b1;
      rsp_data   <= req_write ? 64'd0 : rd_data;
      rsp_source <= req_source;
      rsp_denied <= !hit_any;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  for (genvar g = 0; g < N_TILES; g++) begin : g_tile
    tile_reset_fsm #(
      .HOLD_CYCLES(HOLD_CYCLES)
    ) u_fsm (
      .clock      (clock),
      .reset_n    (reset_n),
      .ctrl       (ctrl_d[g]),
      .pulse      (pulse[g]),
      .tile_reset (tile_reset[g]),
      .busy       (tile_busy[g])
    );
  end

endmodule
